// File: rtl/seq_divider16_pkg.sv
// Shared definitions for the sequential restoring divider: default width and FSM states.
package seq_divider16_pkg;

    localparam int unsigned DivW = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_divider16_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then compare and subtract.
module seq_divider16_div_step #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] rem_i,
    input  logic         next_bit_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         qbit_o
);

    logic [W:0] t;

    always_comb begin
        t      = {rem_i, next_bit_i};
        qbit_o = (t >= {1'b0, divisor_i});
        // rem_i < divisor_i, so the difference always fits back into W bits.
        rem_o  = qbit_o ? (t[W-1:0] - divisor_i) : t[W-1:0];
    end

endmodule

// File: rtl/seq_divider16.sv
// Sequential restoring divider, 2W/W -> W quotient and W remainder, one quotient bit per clock,
// with valid/ready handshakes and early completion on divide-by-zero or quotient overflow.
module seq_divider16
    import seq_divider16_pkg::*;
#(
    parameter int unsigned W = DivW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           dbz,
    output logic           ovf
);

    localparam int unsigned CntW = $clog2(W);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    dvsr_q, dvsr_d;
    logic            dbz_q, dbz_d;
    logic            ovf_q, ovf_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [W-1:0]    step_rem;
    logic            step_qbit;

    // quot_q doubles as the dividend shift register: low dividend bits leave at the MSB
    // while quotient bits enter at the LSB, so after W steps it holds the quotient.
    seq_divider16_div_step #(
        .W (W)
    ) u_step (
        .rem_i      (rem_q),
        .next_bit_i (quot_q[W-1]),
        .divisor_i  (dvsr_q),
        .rem_o      (step_rem),
        .qbit_o     (step_qbit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    dvsr_d = divisor;
                    cnt_d  = '0;
                    if (divisor == '0) begin
                        state_d = StDone;
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                        quot_d  = '1;
                        rem_d   = dividend[W-1:0];
                    end else if (dividend[2*W-1:W] >= divisor) begin
                        state_d = StDone;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                        quot_d  = '1;
                        rem_d   = '0;
                    end else begin
                        state_d = StCalc;
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b0;
                        quot_d  = dividend[W-1:0];
                        rem_d   = dividend[2*W-1:W];
                    end
                end
            end
            StCalc: begin
                rem_d  = step_rem;
                quot_d = {quot_q[W-2:0], step_qbit};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CntW'(W - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dvsr_q      <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dvsr_q      <= dvsr_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_divider16.sv
// Directed and randomized checks of seq_divider16 against an arithmetic reference model.
module tb_seq_divider16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        dbz;
    logic        ovf;

    int total;
    int bad;

    seq_divider16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Full operation: issue, measure latency, check result, apply hold cycles of backpressure
    // (optionally with a competing request on the input), then take the result.
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, input int hold,
                          input bit junk);
        logic [31:0] q_full;
        logic [15:0] eq, er;
        logic        edbz, eovf;
        int          elat;
        int          n;

        if (dv == 16'd0) begin
            edbz = 1'b1; eovf = 1'b0; eq = 16'hFFFF; er = dd[15:0]; elat = 0;
        end else begin
            q_full = dd / {16'd0, dv};
            if (q_full > 32'h0000FFFF) begin
                edbz = 1'b0; eovf = 1'b1; eq = 16'hFFFF; er = 16'd0; elat = 0;
            end else begin
                edbz = 1'b0; eovf = 1'b0; eq = q_full[15:0];
                er = 16'(dd % {16'd0, dv}); elat = 16;
            end
        end

        @(negedge clk);
        dividend  = dd;
        divisor   = dv;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, elat);
        chk("quotient", {16'd0, quotient}, {16'd0, eq});
        chk("remainder", {16'd0, remainder}, {16'd0, er});
        chk("dbz", {31'd0, dbz}, {31'd0, edbz});
        chk("ovf", {31'd0, ovf}, {31'd0, eovf});

        for (int i = 0; i < hold; i++) begin
            if (junk) begin
                in_valid = 1'b1;
                dividend = 32'd1000;
                divisor  = 16'd3;
            end
            @(posedge clk);
            #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_quotient", {16'd0, quotient}, {16'd0, eq});
            chk("hold_remainder", {16'd0, remainder}, {16'd0, er});
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("taken_out_valid", {31'd0, out_valid}, 32'd0);
        chk("taken_in_ready", {31'd0, in_ready}, 32'd1);
        chk("taken_quotient_held", {16'd0, quotient}, {16'd0, eq});
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rdv;
        logic [15:0] rhi;
        logic [15:0] rlo;
        int          sel;

        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_quotient", {16'd0, quotient}, 32'd0);
        chk("rst_remainder", {16'd0, remainder}, 32'd0);
        chk("rst_flags", {30'd0, dbz, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd100, 16'd7, 0, 1'b0);
        run_op(32'hFFFE0001, 16'hFFFF, 0, 1'b0);
        run_op(32'h0000FFFF, 16'h0001, 0, 1'b0);
        run_op(32'h12345678, 16'h0000, 0, 1'b0);
        run_op(32'h00010000, 16'h0001, 0, 1'b0);
        run_op(32'h00050000, 16'h0005, 0, 1'b0);

        // Backpressure with a competing request, then the held request goes through.
        run_op(32'd100, 16'd7, 5, 1'b1);
        run_op(32'd1000, 16'd3, 0, 1'b0);

        // Asynchronous reset in the middle of a calculation.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 16'd7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_quotient", {16'd0, quotient}, 32'd0);
        chk("midrst_remainder", {16'd0, remainder}, 32'd0);
        chk("midrst_flags", {30'd0, dbz, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd1000, 16'd3, 0, 1'b0);

        for (int k = 0; k < 2500; k++) begin
            sel = int'($urandom_range(0, 9));
            rdv = 16'($urandom);
            rhi = 16'($urandom);
            rlo = 16'($urandom);
            if (sel == 0) begin
                rdv = 16'd0;
            end else if (sel >= 3 && rdv != 16'd0) begin
                rhi = rhi % rdv;
            end
            run_op({rhi, rlo}, rdv, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
